// File: rtl/ripple_accumulator.sv
// ripple_accumulator: sums groups of 2**LOG2_TERMS operands through a
// ripple carry adder, handing each total out over a valid/ready port.

module ripple_carry_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[WIDTH];

endmodule

module ripple_accumulator #(
  parameter int WIDTH      = 2,
  parameter int LOG2_TERMS = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [WIDTH-1:0]              i_term,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic [WIDTH+LOG2_TERMS-1:0]   o_sum,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [LOG2_TERMS-1:0]         o_count
);

  localparam int SUM_W   = WIDTH + LOG2_TERMS;
  localparam int N_TERMS = 2 ** LOG2_TERMS;
  // A zero-bit count port still elaborates as two bits wide.
  localparam int CW      = (LOG2_TERMS > 0) ? LOG2_TERMS : 2;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t           state;
  logic [SUM_W-1:0] acc;
  logic [SUM_W-1:0] term_ext;
  logic [SUM_W-1:0] add_sum;
  logic             add_cout;
  logic             unused_carry;
  logic             take;
  logic             give;

  assign term_ext = SUM_W'(i_term);
  assign take     = i_valid & o_ready;
  assign give     = o_valid & i_ready;

  ripple_carry_adder #(
    .WIDTH (SUM_W)
  ) u_add (
    .a    (acc),
    .b    (term_ext),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // The group total always fits in SUM_W, so the carry is never set.
  assign unused_carry = add_cout;

  // Group FSM: collect N_TERMS operands, then hold the total until taken.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      acc     <= '0;
      o_sum   <= '0;
      o_valid <= 1'b0;
      o_ready <= 1'b1;
      o_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (take) begin
            if (N_TERMS == 1) begin
              o_sum   <= term_ext;
              o_valid <= 1'b1;
              o_ready <= 1'b0;
              state   <= DONE;
            end else begin
              acc     <= term_ext;
              o_count <= CW'(1);
              state   <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (take) begin
            acc <= add_sum;
            if (o_count == CW'(N_TERMS - 1)) begin
              o_sum   <= add_sum;
              o_valid <= 1'b1;
              o_ready <= 1'b0;
              o_count <= '0;
              state   <= DONE;
            end else begin
              o_count <= o_count + CW'(1);
            end
          end
        end
        DONE: begin
          if (give) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            acc     <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ripple_accumulator.sv
// tb_ripple_accumulator: vector table, corner sequences and random
// traffic against a queue-based group-sum model.

module tb_ripple_accumulator;

  localparam int W  = 2;
  localparam int L  = 2;
  localparam int N  = 4;
  localparam int SW = W + L;

  logic          clk = 0;
  logic          rst;
  logic [W-1:0]  term;
  logic          valid;
  logic          o_ready;
  logic [SW-1:0] o_sum;
  logic          o_valid;
  logic          ready_in;
  logic [L-1:0]  o_count;

  logic          rst2;
  logic [3:0]    term2;
  logic          valid2;
  logic          o_ready2;
  logic [6:0]    o_sum2;
  logic          o_valid2;
  logic          ready_in2;
  logic [2:0]    o_count2;

  always #5 clk = ~clk;

  ripple_accumulator #(.WIDTH(W), .LOG2_TERMS(L)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_term  (term),
    .i_valid (valid),
    .o_ready (o_ready),
    .o_sum   (o_sum),
    .o_valid (o_valid),
    .i_ready (ready_in),
    .o_count (o_count)
  );

  ripple_accumulator #(.WIDTH(4), .LOG2_TERMS(3)) dut2 (
    .i_clk   (clk),
    .i_rst   (rst2),
    .i_term  (term2),
    .i_valid (valid2),
    .o_ready (o_ready2),
    .o_sum   (o_sum2),
    .o_valid (o_valid2),
    .i_ready (ready_in2),
    .o_count (o_count2)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int m_q[$];
  int m_sum;
  bit m_pend;

  typedef struct {
    int t[4];
    bit gap;
    int hold;
    int exp;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic chkx(string n, logic [31:0] act, int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0h want %0d (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  // One clock: update the group model from the inputs, then compare.
  task automatic tick();
    bit acc_m;
    bit con_m;
    int s;
    acc_m = valid && !m_pend;
    con_m = ready_in && m_pend;
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_q.delete();
      m_pend = 0;
    end else if (con_m) begin
      m_pend = 0;
    end else if (acc_m) begin
      m_q.push_back(int'(term));
      if (m_q.size() == N) begin
        s = 0;
        foreach (m_q[i]) s += m_q[i];
        m_sum  = s;
        m_pend = 1;
        m_q.delete();
      end
    end
    #1;
    chkx("ready", 32'(o_ready), int'(!m_pend));
    chkx("valid", 32'(o_valid), int'(m_pend));
    chkx("count", 32'(o_count), m_q.size());
    if (m_pend) chkx("sum", 32'(o_sum), m_sum);
  endtask

  task automatic tick2();
    @(posedge clk);
    #1;
  endtask

  int rises[$];
  int sums[$];
  bit prev_v;
  int idx;
  int guard;
  int seq[8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{t: '{3, 3, 3, 3}, gap: 0, hold: 0, exp: 12};
    tbl[1] = '{t: '{0, 1, 2, 1}, gap: 1, hold: 0, exp: 4};
    tbl[2] = '{t: '{1, 2, 3, 0}, gap: 0, hold: 5, exp: 6};
    tbl[3] = '{t: '{1, 1, 1, 1}, gap: 0, hold: 0, exp: 4};

    rst = 1; term = 0; valid = 0; ready_in = 1;
    rst2 = 1; term2 = 0; valid2 = 0; ready_in2 = 1;
    m_pend = 0; m_sum = 0;
    tick();
    tick();
    chkx("rst_sum", 32'(o_sum), 0);
    chkx("rst_valid", 32'(o_valid), 0);
    chkx("rst_count", 32'(o_count), 0);
    chkx("rst_ready", 32'(o_ready), 1);
    rst = 0;

    foreach (tbl[v]) begin
      ready_in = (tbl[v].hold == 0);
      for (int k = 0; k < N; k++) begin
        valid = 1;
        term  = W'(tbl[v].t[k]);
        tick();
        if (tbl[v].gap && k < N - 1) begin
          valid = 0;
          term  = 2'(k);
          tick();
          tick();
          chk("gap_count", int'(o_count), k + 1);
        end
      end
      chk("tbl_sum", int'(o_sum), tbl[v].exp);
      chk("tbl_valid", int'(o_valid), 1);
      valid = 1;
      term  = 3;
      for (int h = 0; h < tbl[v].hold; h++) begin
        tick();
        chk("hold_sum", int'(o_sum), tbl[v].exp);
        chk("hold_ready", int'(o_ready), 0);
      end
      valid = 0;
      ready_in = 1;
      tick();
      chk("consumed", int'(o_valid), 0);
    end

    // Reset in the middle of a group.
    valid = 1; term = 3;
    tick();
    tick();
    chk("mid_count", int'(o_count), 2);
    valid = 0; rst = 1;
    tick();
    rst = 0;
    chk("mr_count", int'(o_count), 0);
    chk("mr_valid", int'(o_valid), 0);
    chk("mr_ready", int'(o_ready), 1);
    seq[0] = 1; seq[1] = 0; seq[2] = 0; seq[3] = 0;
    valid = 1;
    for (int k = 0; k < 4; k++) begin
      term = W'(seq[k]);
      tick();
    end
    valid = 0;
    chk("mr_sum", int'(o_sum), 1);
    tick();

    // Back-to-back groups with i_ready tied high.
    seq = '{3, 3, 3, 3, 1, 2, 3, 0};
    ready_in = 1;
    idx = 0;
    guard = 0;
    prev_v = 0;
    rises.delete();
    sums.delete();
    while (rises.size() < 2 && guard < 40) begin
      if (idx < 8) begin
        valid = 1;
        term  = W'(seq[idx]);
        if (!m_pend) idx++;
      end else begin
        valid = 0;
      end
      tick();
      if (o_valid && !prev_v) begin
        rises.push_back(cyc);
        sums.push_back(int'(o_sum));
      end
      prev_v = o_valid;
      guard++;
    end
    chk("b2b_results", rises.size(), 2);
    if (rises.size() == 2) begin
      chk("b2b_gap", rises[1] - rises[0], N + 1);
      chk("b2b_sum0", sums[0], 12);
      chk("b2b_sum1", sums[1], 6);
    end
    valid = 0;
    tick();

    // Random traffic against the model.
    for (int r = 0; r < 600; r++) begin
      valid    = ($urandom_range(0, 3) != 0);
      term     = W'($urandom);
      ready_in = ($urandom_range(0, 2) != 0);
      rst      = ($urandom_range(0, 59) == 0);
      tick();
    end
    rst = 0;

    // Wide instance: eight terms of 15.
    tick2();
    rst2 = 0;
    valid2 = 1;
    term2 = 15;
    for (int k = 0; k < 8; k++) begin
      tick2();
      chk("w_count", int'(o_count2), (k + 1) % 8);
      chk("w_valid", int'(o_valid2), int'(k == 7));
    end
    valid2 = 0;
    chk("w_sum", int'(o_sum2), 120);
    chk("w_ready", int'(o_ready2), 0);
    tick2();
    chk("w_consumed", int'(o_valid2), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
